// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizing helpers for the data memory controller.
//   state_t     controller FSM states (IDLE, WAIT, RESP)
//   BYTE_LANES  byte lanes of the default 32-bit data path
//   OFFS_W      byte-offset bits of the default data path
//   byte_lanes(), offs_w(), idx_w()  sizing helpers for parameterised instances
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned BYTE_LANES = DEF_DATA_W / 8;
  localparam int unsigned OFFS_W     = $clog2(BYTE_LANES);

  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned offs_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index width; never zero so single-word arrays still get a port.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W storage with per-byte write enables.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low clear of every word
//   wr_en    in   commit wr_data lanes selected by wr_be at idx
//   wr_be    in   byte-lane enables
//   idx      in   word index (shared by read and write)
//   wr_data  in   write data
//   rd_data  out  combinational read of word idx
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [byte_lanes(DATA_W)-1:0]   wr_be,
  input  logic [idx_w(DEPTH)-1:0]         idx,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [DATA_W-1:0]               rd_data
);

  localparam int unsigned LANES = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (wr_be[b]) begin
          mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word-addressed RAM behind a valid/ready request and a
// one-cycle response pulse, with WAIT_STATES wait cycles, byte-lane writes,
// and alignment/range error reporting.
// Ports:
//   clk, reset                    clock; synchronous active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_we/addr/wdata/be          request fields (byte address)
//   rsp_valid                     one-cycle response pulse
//   rsp_rdata/rsp_err             response data/error, held outside RESP
//   rd_count/wr_count/err_count   saturating perf counters
// Build option: DMEM_PERF_EN enables the perf counters; otherwise the
// count ports are tied to zero.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [byte_lanes(DATA_W)-1:0] req_be,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [31:0]                   rd_count,
  output logic [31:0]                   wr_count,
  output logic [31:0]                   err_count
);

  localparam int unsigned LANES    = byte_lanes(DATA_W);
  localparam int unsigned OFFS     = offs_w(DATA_W);
  localparam int unsigned IW       = idx_w(DEPTH);
  localparam int unsigned CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int unsigned LAST_CNT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [LANES-1:0]   lat_be;

  logic               accept;
  logic               acc_go;
  logic               acc_we;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [LANES-1:0]   acc_be;
  logic [ADDR_W-1:0]  acc_word;
  logic               acc_err;
  logic [IW-1:0]      acc_idx;
  logic [DATA_W-1:0]  arr_rdata;

  assign accept = req_valid && req_ready;

  // With no wait states the access is taken straight from the request
  // port on the accept edge; otherwise from the latched request on the
  // last wait count.
  always_comb begin
    acc_go    = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    acc_be    = '0;
    if (WAIT_STATES == 0) begin
      acc_go    = accept;
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_go    = (state == WAIT) && (wait_cnt == CNT_W'(LAST_CNT));
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
  end

  always_comb begin
    acc_word = acc_addr >> OFFS;
    acc_err  = ((acc_addr & ADDR_W'(LANES - 1)) != '0) ||
               (acc_word >= ADDR_W'(DEPTH));
    acc_idx  = acc_word[IW-1:0];
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (acc_go && acc_we && !acc_err),
    .wr_be   (acc_be),
    .idx     (acc_idx),
    .wr_data (acc_wdata),
    .rd_data (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      // Writes leave rsp_rdata untouched; errors force it to zero.
      if (acc_go) begin
        rsp_err <= acc_err;
        if (acc_err) begin
          rsp_rdata <= '0;
        end else if (!acc_we) begin
          rsp_rdata <= arr_rdata;
        end
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            req_ready <= 1'b0;
            wait_cnt  <= '0;
            if (WAIT_STATES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (acc_go) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef DMEM_PERF_EN
  logic [31:0] rd_q;
  logic [31:0] wr_q;
  logic [31:0] err_q;

  // rsp_err and lat_we still describe the access being answered in RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      err_q <= '0;
    end else if (state == RESP) begin
      if (rsp_err) begin
        if (err_q != '1) err_q <= err_q + 32'd1;
      end else if (lat_we) begin
        if (wr_q != '1) wr_q <= wr_q + 32'd1;
      end else begin
        if (rd_q != '1) rd_q <= rd_q + 32'd1;
      end
    end
  end

  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign err_count = err_q;
`else
  assign rd_count  = '0;
  assign wr_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a default instance (WAIT_STATES=2) driven by
// directed and random transactions against an array-based reference, plus
// a WAIT_STATES=0 instance for back-to-back handshake timing.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, rd_count, wr_count, err_count;

  logic        req_valid_z, req_ready_z, req_we_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [3:0]  req_be_z;
  logic        rsp_valid_z, rsp_err_z;
  logic [31:0] rsp_rdata_z, rd_count_z, wr_count_z, err_count_z;

  data_memory_ctrl #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH       (256),
    .WAIT_STATES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .err_count (err_count)
  );

  data_memory_ctrl #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH       (256),
    .WAIT_STATES (0)
  ) dut_z (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid_z),
    .req_ready (req_ready_z),
    .req_we    (req_we_z),
    .req_addr  (req_addr_z),
    .req_wdata (req_wdata_z),
    .req_be    (req_be_z),
    .rsp_valid (rsp_valid_z),
    .rsp_rdata (rsp_rdata_z),
    .rsp_err   (rsp_err_z),
    .rd_count  (rd_count_z),
    .wr_count  (wr_count_z),
    .err_count (err_count_z)
  );

  int checks = 0;
  int errors = 0;

  // Reference: plain word array plus the spec's response/counter rules.
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          exp_rd, exp_wr, exp_errc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    exp_rd    = 0;
    exp_wr    = 0;
    exp_errc  = 0;
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
    int unsigned word;
    word = addr / 4;
    exp_err = (addr % 4 != 0) || (word >= 256);
    if (exp_err) begin
      exp_rdata = 32'h0;
      exp_errc++;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[word][b*8 +: 8] = wdata[b*8 +: 8];
      exp_wr++;
    end else begin
      exp_rdata = ref_mem[word];
      exp_rd++;
    end
  endtask

  // One transaction on the default instance. While the controller is busy
  // the request stays valid with a junk write, which must be ignored.
  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be);
    int lat;
    @(negedge clk);
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 32'($urandom_range(0, 15)) << 2;
    req_wdata = $urandom;
    req_be    = 4'hF;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    model_access(we, addr, wdata, be);
    check("latency", 32'(lat), 32'd3);
    check("ready_in_resp", {31'b0, req_ready}, 32'd0);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    @(negedge clk);
    check("pulse_one_cycle", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned sel;

    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rd_count", rd_count, 32'd0);
    check("rst_ready_z", {31'b0, req_ready_z}, 32'd1);
    reset = 1'b1;

    // Defaults: write then read back.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    check("t1_const", rsp_rdata, 32'hDEADBEEF);

    // Byte lanes.
    txn(1'b1, 32'h14, 32'h11223344, 4'hF);
    txn(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101);
    txn(1'b0, 32'h14, 32'h0, 4'hF);
    check("t2_const", rsp_rdata, 32'h11BB33DD);

    // Errors: misaligned read, out-of-range write, word 0 untouched.
    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    txn(1'b0, 32'h12, 32'h0, 4'hF);
    txn(1'b1, 32'h400, 32'h55555555, 4'hF);
    txn(1'b0, 32'h0, 32'h0, 4'hF);
    check("t3_const", rsp_rdata, 32'hCAFEF00D);
    // No-op write with be=0 is acked without error.
    txn(1'b1, 32'h0, 32'h12345678, 4'h0);
    txn(1'b0, 32'h0, 32'h0, 4'h0);

    // Random mix.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      else               a = 32'($urandom_range(256, 1023)) << 2;
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Perf counters, checked before the reset below clears them.
`ifdef DMEM_PERF_EN
    check("rd_count", rd_count, 32'(exp_rd));
    check("wr_count", wr_count, 32'(exp_wr));
    check("err_count", err_count, 32'(exp_errc));
`else
    check("rd_count_off", rd_count, 32'd0);
    check("wr_count_off", wr_count, 32'd0);
    check("err_count_off", err_count, 32'd0);
`endif

    // Reset in the middle of a write: no response, nothing committed.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFEEDFACE; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'b0, rsp_valid}, 32'd0);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_valid2", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("midrst_valid3", {31'b0, rsp_valid}, 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'hF);
    check("t5_const", rsp_rdata, 32'h0);

    // Zero-wait-state instance, request held valid back to back.
    @(negedge clk);
    check("z_ready0", {31'b0, req_ready_z}, 32'd1);
    req_valid_z = 1'b1; req_we_z = 1'b1; req_addr_z = 32'h4;
    req_wdata_z = 32'hA5A5_0F0F; req_be_z = 4'hF;
    @(negedge clk);
    check("z_valid1", {31'b0, rsp_valid_z}, 32'd1);
    check("z_ready1", {31'b0, req_ready_z}, 32'd0);
    check("z_err1", {31'b0, rsp_err_z}, 32'd0);
    req_we_z = 1'b0;
    @(negedge clk);
    check("z_valid2", {31'b0, rsp_valid_z}, 32'd0);
    check("z_ready2", {31'b0, req_ready_z}, 32'd1);
    @(negedge clk);
    req_valid_z = 1'b0;
    check("z_valid3", {31'b0, rsp_valid_z}, 32'd1);
    check("z_ready3", {31'b0, req_ready_z}, 32'd0);
    check("z_rdata3", rsp_rdata_z, 32'hA5A5_0F0F);
    @(negedge clk);
    check("z_valid4", {31'b0, rsp_valid_z}, 32'd0);
`ifdef DMEM_PERF_EN
    check("z_rd_count", rd_count_z, 32'd1);
    check("z_wr_count", wr_count_z, 32'd1);
`else
    check("z_rd_count_off", rd_count_z, 32'd0);
    check("z_wr_count_off", wr_count_z, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
